fp_div: RTL and testbench
=========================

FP_DIV -- requirements
Module: fp_div

Interface
REQ-001 SHALL have parameter WIDTH, default 16, selecting the IEEE-754 format: 16, 32 or 64.
REQ-002 SHALL have port clk, input, 1 bit: the only clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: synchronous active-low reset.
REQ-004 SHALL have port in_valid, input, 1 bit: operands present.
REQ-005 SHALL have port in_ready, output, 1 bit: unit can accept operands.
REQ-006 SHALL have ports a and b, input, WIDTH bits each: dividend and divisor.
REQ-007 SHALL have port rm, input, 3 bits: rounding mode, using the codebase rounding codes (RNE etc.).
REQ-008 SHALL have port out_valid, output, 1 bit: result held and valid.
REQ-009 SHALL have port out_ready, input, 1 bit: consumer accepts the result.
REQ-010 SHALL have port result, output, WIDTH bits: quotient a/b.
REQ-011 SHALL have port div_by_zero, output, 1 bit: finite nonzero a divided by zero, qualified by out_valid.

Function
REQ-012 SHALL derive EXP_W, EXP_BIAS and MANT_W from WIDTH: 5/15/10, 8/127/23, 11/1023/52.
REQ-013 SHALL use an FSM with states IDLE, PREP, ITER, ROUND, DONE.
REQ-014 SHALL assert in_ready only in IDLE; an input is accepted when in_valid and in_ready are both high, and a, b and rm are captured.
REQ-015 SHALL go from IDLE to PREP on accept, where it does the following:
- unpack a and b; classify NaN, inf, zero and subnormal;
- normalize subnormal significands with a priority encoder and adjust the exponents;
- compute exp = ea - eb + EXP_BIAS in a signed EXP_W+2 bit value;
- compute sign = sa ^ sb.
REQ-016 SHALL handle special cases in PREP by going straight to DONE, skipping ITER:
- any NaN, 0/0 or inf/inf -> QNAN, which is 0, all-ones exponent, mantissa MSB set;
- x/0 with finite nonzero x -> signed inf and div_by_zero=1;
- inf/finite -> signed inf;
- 0/nonzero or finite/inf -> signed zero.
REQ-017 SHALL perform, in ITER, one restoring radix-2 quotient bit per cycle, for exactly MANT_W+3 cycles; a down-counter loaded in PREP stops at zero. This yields the implicit bit, MANT_W mantissa bits, guard and round; sticky = (remainder != 0).
REQ-018 SHALL, when the dividend significand is smaller than the divisor significand, pre-shift the dividend left by 1 in PREP and decrement exp so that the quotient MSB is 1.
REQ-019 SHALL perform rounding in ROUND with grs_rounder, adding the rounder overflow to exp, as follows:
- exp >= all-ones -> signed inf;
- exp <= 0 -> per REQ-027.
REQ-020 SHALL hold result and div_by_zero stable in DONE with out_valid=1 until out_ready=1, then return to IDLE in the following cycle.
REQ-021 SHALL have a normal-path latency of MANT_W+6 cycles from accept to out_valid (fp16: 16) and a special-path latency of 2 cycles.
REQ-022 SHALL ignore in_valid outside IDLE; there is no back-to-back accept in the same cycle as the DONE handshake.
REQ-023 SHALL hold a sign-correct zero result when exp underflows and the result is flushed.

Reset
REQ-024 SHALL, while rst_n=0 at a clock edge, put the FSM in IDLE with in_ready=1, out_valid=0, result=+0, div_by_zero=0 and the counter at 0.
REQ-025 SHALL, on a reset in any state mid-operation, abandon the operation; no result is emitted.

Configuration
REQ-026 SHALL use macro FP_DIV_SUBNORMAL_EN to gate subnormal outputs.
REQ-027 SHALL behave as follows on underflow:
- with FP_DIV_SUBNORMAL_EN defined: when exp <= 0, right-shift the quotient by 1-exp, OR the shifted-out bits into sticky, round and emit a subnormal or zero (a round-up to the min normal sets exponent 1);
- without it: flush to signed zero.

Structure
REQ-028 SHALL place the format constants, the QNAN/inf/zero builders and the FSM state enum in the shared package fp_pkg; the rounding-mode codes stay in the existing rounding header.
REQ-029 SHALL instantiate the existing grs_rounder as its only sub-module, with input width MANT_W+3+1 (sticky) and output width MANT_W+1.

Verification
REQ-030 SHALL cover a=0x3C00, b=0x3C00, RNE -> result 0x3C00, 16 cycles, div_by_zero=0.
REQ-031 SHALL cover a=0x3C00, b=0x4200 (1/3): RNE -> 0x3555; round-up mode -> 0x3556.
REQ-032 SHALL cover a=0x4600, b=0xC000 -> 0xC200; and a=0x7BFF, b=0x0400 -> 0x7C00 (overflow).
REQ-033 SHALL cover a=0x3C00, b=0x0000 -> 0x7C00 with div_by_zero=1 after 2 cycles; and a=0x0000, b=0x8000 -> 0x7E00.
REQ-034 SHALL cover out_ready held low for 5 cycles in DONE -> result stable, in_ready=0, and new in_valid ignored.
REQ-035 SHALL cover rst_n=0 during cycle 5 of ITER -> next cycle IDLE, out_valid=0, and no stale result after reset.

Source files
------------

// File: rtl/fp_pkg.sv
// IEEE-754 format constants, special-value builders and the divider FSM states.
package fp_pkg;
    typedef enum logic [2:0] {IDLE, PREP, ITER, ROUND, DONE} div_state_e;

    function automatic int fp_exp_w(input int w);
        return (w == 64) ? 11 : (w == 32) ? 8 : 5;
    endfunction

    function automatic int fp_mant_w(input int w);
        return (w == 64) ? 52 : (w == 32) ? 23 : 10;
    endfunction

    function automatic int fp_bias(input int w);
        return (w == 64) ? 1023 : (w == 32) ? 127 : 15;
    endfunction

    // Builders return a 64-bit container; callers size-cast to their width.
    function automatic logic [63:0] fp_zero(input int w, input logic s);
        logic [63:0] r;
        r        = '0;
        r[w-1]   = s;
        return r;
    endfunction

    function automatic logic [63:0] fp_inf(input int w, input logic s);
        logic [63:0] r;
        r = '0;
        for (int i = 0; i < 64; i++)
            if (i >= fp_mant_w(w) && i < w - 1) r[i] = 1'b1;
        r[w-1] = s;
        return r;
    endfunction

    function automatic logic [63:0] fp_qnan(input int w);
        logic [63:0] r;
        r = fp_inf(w, 1'b0);
        r[fp_mant_w(w)-1] = 1'b1;
        return r;
    endfunction
endpackage

// File: rtl/fp_rm_pkg.sv
// Rounding-mode codes shared by every floating-point unit in the codebase.
package fp_rm_pkg;
    localparam logic [2:0] RM_RNE = 3'd0;
    localparam logic [2:0] RM_RTZ = 3'd1;
    localparam logic [2:0] RM_RDN = 3'd2;
    localparam logic [2:0] RM_RUP = 3'd3;
    localparam logic [2:0] RM_RMM = 3'd4;
endpackage

// File: rtl/grs_rounder.sv
// Rounds a significand carrying guard/round/sticky bits to OUT_W bits; carry flags a round-up overflow.
module grs_rounder
    import fp_rm_pkg::*;
#(
    parameter int IN_W  = 14,
    parameter int OUT_W = 11
) (
    input  logic [IN_W-1:0]  in_sig,
    input  logic             sign,
    input  logic [2:0]       rm,
    output logic [OUT_W-1:0] out_sig,
    output logic             carry
);
    logic [OUT_W-1:0] keep;
    logic             g, rs, inc;
    logic [OUT_W:0]   sum;

    always_comb begin
        keep = in_sig[IN_W-1 -: OUT_W];
        g    = in_sig[IN_W-OUT_W-1];
        rs   = |in_sig[IN_W-OUT_W-2:0];
        case (rm)
            RM_RNE:  inc = g & (rs | keep[0]);
            RM_RTZ:  inc = 1'b0;
            RM_RDN:  inc = sign & (g | rs);
            RM_RUP:  inc = ~sign & (g | rs);
            RM_RMM:  inc = g;
            default: inc = 1'b0;
        endcase
        sum     = {1'b0, keep} + {{OUT_W{1'b0}}, inc};
        out_sig = sum[OUT_W-1:0];
        carry   = sum[OUT_W];
    end
endmodule

// File: rtl/fp_div.sv
// Multi-cycle IEEE-754 divider: restoring radix-2, one quotient bit per cycle.
// Define FP_DIV_SUBNORMAL_EN to produce subnormal results instead of flushing to zero.
module fp_div
    import fp_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       rm,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             div_by_zero
);
    localparam int EXP_W    = fp_exp_w(WIDTH);
    localparam int MANT_W   = fp_mant_w(WIDTH);
    localparam int EXP_BIAS = fp_bias(WIDTH);
    localparam int SIG_W    = MANT_W + 1;
    localparam int REM_W    = MANT_W + 2;
    localparam int QUO_W    = MANT_W + 3;
    localparam int RND_W    = MANT_W + 4;
    localparam int CNT_W    = $clog2(MANT_W + 4);
    localparam int SH_W     = $clog2(MANT_W + 1);

    typedef logic signed [EXP_W+1:0] exp_t;
    localparam exp_t EXP_ZERO = exp_t'(0);
    localparam exp_t EXP_ONE  = exp_t'(1);
    localparam exp_t EXP_MAX  = exp_t'((1 << EXP_W) - 1);
    localparam exp_t EXP_BSD  = exp_t'(EXP_BIAS);

    div_state_e       state_q, state_d;
    logic [WIDTH-1:0] op_a_q, op_a_d, op_b_q, op_b_d, result_q, result_d;
    logic [2:0]       rm_q, rm_d;
    logic             sign_q, sign_d, dbz_q, dbz_d;
    exp_t             exp_q, exp_d;
    logic [SIG_W-1:0] div_q, div_d;
    logic [REM_W-1:0] rem_q, rem_d;
    logic [QUO_W-1:0] quo_q, quo_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [EXP_W-1:0]  ea_f, eb_f;
    logic [MANT_W-1:0] fa, fb;
    logic              a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, a_sub, b_sub, special;
    logic [SH_W-1:0]   lza, lzb;
    logic [SIG_W-1:0]  ma, mb;
    exp_t              ea, eb, exp_pre, exp_r;
    logic              ge, sticky;
    logic [REM_W-1:0]  diff;
    logic [RND_W-1:0]  rnd_in;
    logic [SIG_W-1:0]  rnd_out;
    logic              rnd_carry;

    // Shift that brings the top set bit of a subnormal fraction to the implicit position.
    function automatic logic [SH_W-1:0] lzc(input logic [MANT_W-1:0] f);
        lzc = SH_W'(MANT_W);
        for (int i = 0; i < MANT_W; i++)
            if (f[i]) lzc = SH_W'(MANT_W - i);
    endfunction

    grs_rounder #(.IN_W(RND_W), .OUT_W(SIG_W)) u_rnd (
        .in_sig  (rnd_in),
        .sign    (sign_q),
        .rm      (rm_q),
        .out_sig (rnd_out),
        .carry   (rnd_carry)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            op_a_q   <= '0;
            op_b_q   <= '0;
            rm_q     <= '0;
            sign_q   <= 1'b0;
            dbz_q    <= 1'b0;
            exp_q    <= '0;
            div_q    <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            op_a_q   <= op_a_d;
            op_b_q   <= op_b_d;
            rm_q     <= rm_d;
            sign_q   <= sign_d;
            dbz_q    <= dbz_d;
            exp_q    <= exp_d;
            div_q    <= div_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid) state_d = PREP;
            PREP:    state_d = special ? DONE : ITER;
            ITER:    if (cnt_q == CNT_W'(1)) state_d = ROUND;
            ROUND:   state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
    end

    always_comb begin
        ea_f    = op_a_q[WIDTH-2 -: EXP_W];
        eb_f    = op_b_q[WIDTH-2 -: EXP_W];
        fa      = op_a_q[MANT_W-1:0];
        fb      = op_b_q[MANT_W-1:0];
        a_zero  = (ea_f == '0) && (fa == '0);
        b_zero  = (eb_f == '0) && (fb == '0);
        a_sub   = (ea_f == '0) && (fa != '0);
        b_sub   = (eb_f == '0) && (fb != '0);
        a_inf   = (&ea_f) && (fa == '0);
        b_inf   = (&eb_f) && (fb == '0);
        a_nan   = (&ea_f) && (fa != '0);
        b_nan   = (&eb_f) && (fb != '0);
        special = a_zero | b_zero | a_inf | b_inf | a_nan | b_nan;
        lza     = lzc(fa);
        lzb     = lzc(fb);
        ma      = a_sub ? ({1'b0, fa} << lza) : {1'b1, fa};
        mb      = b_sub ? ({1'b0, fb} << lzb) : {1'b1, fb};
        ea      = a_sub ? EXP_ONE - exp_t'(lza) : exp_t'(ea_f);
        eb      = b_sub ? EXP_ONE - exp_t'(lzb) : exp_t'(eb_f);
        exp_pre = ea - eb + EXP_BSD;
    end

    always_comb begin
        ge     = rem_q >= {1'b0, div_q};
        diff   = ge ? rem_q - {1'b0, div_q} : rem_q;
        sticky = |rem_q;
        exp_r  = rnd_carry ? exp_q + EXP_ONE : exp_q;
`ifdef FP_DIV_SUBNORMAL_EN
        begin
            logic [RND_W-1:0] v, vs;
            exp_t             sh;
            logic             lost;
            v  = {quo_q, sticky};
            sh = EXP_ONE - exp_q;
            if (sh > exp_t'(RND_W)) sh = exp_t'(RND_W);
            vs   = v >> sh;
            lost = 1'b0;
            for (int i = 0; i < RND_W; i++)
                if (exp_t'(i) < sh) lost = lost | v[i];
            rnd_in = (exp_q <= EXP_ZERO) ? {vs[RND_W-1:1], vs[0] | lost} : v;
        end
`else
        rnd_in = {quo_q, sticky};
`endif
    end

    always_comb begin
        op_a_d   = op_a_q;
        op_b_d   = op_b_q;
        rm_d     = rm_q;
        sign_d   = sign_q;
        dbz_d    = dbz_q;
        exp_d    = exp_q;
        div_d    = div_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        case (state_q)
            IDLE: if (in_valid) begin
                op_a_d = a;
                op_b_d = b;
                rm_d   = rm;
                dbz_d  = 1'b0;
            end
            PREP: begin
                sign_d = op_a_q[WIDTH-1] ^ op_b_q[WIDTH-1];
                div_d  = mb;
                quo_d  = '0;
                cnt_d  = CNT_W'(QUO_W);
                // Pre-shift keeps the first quotient bit at 1 so the result is already normalized.
                if (ma < mb) begin
                    rem_d = {ma, 1'b0};
                    exp_d = exp_pre - EXP_ONE;
                end else begin
                    rem_d = {1'b0, ma};
                    exp_d = exp_pre;
                end
                if (a_nan | b_nan | (a_zero & b_zero) | (a_inf & b_inf))
                    result_d = WIDTH'(fp_qnan(WIDTH));
                else if (b_zero) begin
                    result_d = WIDTH'(fp_inf(WIDTH, sign_d));
                    dbz_d    = 1'b1;
                end else if (a_inf)
                    result_d = WIDTH'(fp_inf(WIDTH, sign_d));
                else if (a_zero | b_inf)
                    result_d = WIDTH'(fp_zero(WIDTH, sign_d));
            end
            ITER: begin
                quo_d = {quo_q[QUO_W-2:0], ge};
                rem_d = {diff[REM_W-2:0], 1'b0};
                cnt_d = cnt_q - CNT_W'(1);
            end
            ROUND: begin
                if (exp_q <= EXP_ZERO) begin
`ifdef FP_DIV_SUBNORMAL_EN
                    // A round-up into the implicit bit lands on the minimum normal exponent.
                    result_d = {sign_q, {(EXP_W-1){1'b0}}, rnd_out[MANT_W], rnd_out[MANT_W-1:0]};
`else
                    result_d = WIDTH'(fp_zero(WIDTH, sign_q));
`endif
                end else if (exp_r >= EXP_MAX)
                    result_d = WIDTH'(fp_inf(WIDTH, sign_q));
                else
                    result_d = {sign_q, exp_r[EXP_W-1:0], rnd_out[MANT_W-1:0]};
            end
            default: ;
        endcase
    end

    assign result      = result_q;
    assign div_by_zero = dbz_q;
endmodule

// File: tb/tb_fp_div.sv
// Directed-vector bench for the fp16 divider: results, latency, handshake stall and mid-op reset.
module tb_fp_div;
    import fp_rm_pkg::*;

    logic        clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic [15:0] a = '0, b = '0;
    logic [2:0]  rm = '0;
    logic        in_ready, out_valid, div_by_zero;
    logic [15:0] result;

    int n_chk  = 0;
    int n_fail = 0;

    fp_div #(.WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .rm(rm), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [15:0] a;
        logic [15:0] b;
        logic [2:0]  rm;
        logic [15:0] res;
        logic        dbz;
        int          lat;
    } vec_t;

    localparam int NV = 18;
    vec_t vecs [NV];

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Launch one operation and wait (bounded) for out_valid; lat counts edges including the accept edge.
    task automatic run_op(input logic [15:0] ai, input logic [15:0] bi, input logic [2:0] rmi,
                          output logic [15:0] res, output logic dbz, output int lat);
        a = ai; b = bi; rm = rmi; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        res = result;
        dbz = div_by_zero;
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    initial begin
        logic [15:0] res;
        logic        dbz, stale;
        int          lat;

        vecs[0]  = '{"one_div_one",  16'h3C00, 16'h3C00, RM_RNE, 16'h3C00, 1'b0, 16};
        vecs[1]  = '{"third_rne",    16'h3C00, 16'h4200, RM_RNE, 16'h3555, 1'b0, 16};
        vecs[2]  = '{"third_rup",    16'h3C00, 16'h4200, RM_RUP, 16'h3556, 1'b0, 16};
        vecs[3]  = '{"third_rtz",    16'h3C00, 16'h4200, RM_RTZ, 16'h3555, 1'b0, 16};
        vecs[4]  = '{"nthird_rdn",   16'hBC00, 16'h4200, RM_RDN, 16'hB556, 1'b0, 16};
        vecs[5]  = '{"two_thirds",   16'h4000, 16'h4200, RM_RNE, 16'h3955, 1'b0, 16};
        vecs[6]  = '{"six_div_m2",   16'h4600, 16'hC000, RM_RNE, 16'hC200, 1'b0, 16};
        vecs[7]  = '{"overflow",     16'h7BFF, 16'h0400, RM_RNE, 16'h7C00, 1'b0, 16};
        vecs[8]  = '{"max_div_one",  16'h7BFF, 16'h3C00, RM_RNE, 16'h7BFF, 1'b0, 16};
        vecs[9]  = '{"subnorm_in",   16'h0001, 16'h0400, RM_RNE, 16'h1400, 1'b0, 16};
        vecs[10] = '{"underflow",    16'h8400, 16'h7800, RM_RNE, 16'h8000, 1'b0, 16};
        vecs[11] = '{"div_zero",     16'h3C00, 16'h0000, RM_RNE, 16'h7C00, 1'b1, 2};
        vecs[12] = '{"zero_zero",    16'h0000, 16'h8000, RM_RNE, 16'h7E00, 1'b0, 2};
        vecs[13] = '{"inf_div_fin",  16'h7C00, 16'hC000, RM_RNE, 16'hFC00, 1'b0, 2};
        vecs[14] = '{"fin_div_inf",  16'h3C00, 16'h7C00, RM_RNE, 16'h0000, 1'b0, 2};
        vecs[15] = '{"nan_in",       16'h7D00, 16'h3C00, RM_RNE, 16'h7E00, 1'b0, 2};
        vecs[16] = '{"negzero_num",  16'h8000, 16'h3C00, RM_RNE, 16'h8000, 1'b0, 2};
        vecs[17] = '{"inf_inf",      16'h7C00, 16'hFC00, RM_RNE, 16'h7E00, 1'b0, 2};

        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready",  in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_result",    result, 0);
        check("rst_dbz",       div_by_zero, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < NV; i++) begin
            check({vecs[i].name, "_ready"}, in_ready, 1);
            run_op(vecs[i].a, vecs[i].b, vecs[i].rm, res, dbz, lat);
            check({vecs[i].name, "_res"}, res, vecs[i].res);
            check({vecs[i].name, "_dbz"}, dbz, vecs[i].dbz);
            check({vecs[i].name, "_lat"}, lat, vecs[i].lat);
            release_out();
            check({vecs[i].name, "_idle"}, out_valid, 0);
        end

        // Consumer stalls in DONE while a new request is offered.
        run_op(16'h4600, 16'hC000, RM_RNE, res, dbz, lat);
        for (int k = 0; k < 5; k++) begin
            a = 16'h3C00; b = 16'h3C00; in_valid = 1'b1;
            @(posedge clk); #1;
            check("stall_result",   result, 16'hC200);
            check("stall_in_ready", in_ready, 0);
            check("stall_valid",    out_valid, 1);
        end
        in_valid = 1'b0;
        release_out();
        check("stall_back_idle",  in_ready, 1);
        check("stall_valid_drop", out_valid, 0);
        stale = 1'b0;
        repeat (20) begin
            @(posedge clk); #1;
            if (out_valid) stale = 1'b1;
        end
        check("stall_req_ignored", stale, 0);

        // Reset during the fifth ITER cycle abandons the operation.
        a = 16'h3C00; b = 16'h4200; rm = RM_RNE; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("midrst_in_ready",  in_ready, 1);
        check("midrst_out_valid", out_valid, 0);
        check("midrst_result",    result, 0);
        check("midrst_dbz",       div_by_zero, 0);
        rst_n = 1'b1;
        stale = 1'b0;
        repeat (20) begin
            @(posedge clk); #1;
            if (out_valid) stale = 1'b1;
        end
        check("midrst_no_stale", stale, 0);
        run_op(16'h4000, 16'h3C00, RM_RNE, res, dbz, lat);
        check("post_rst_res", res, 16'h4000);
        check("post_rst_lat", lat, 16);
        release_out();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
